// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 binary-coded-modulation scanner.
package hub75_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StWait, StLatch} shift_state_e;

  // Channel position inside a lane (R is the most significant group).
  localparam int unsigned ChR = 2;
  localparam int unsigned ChG = 1;
  localparam int unsigned ChB = 0;

  // Width of the OE timer: BLANK dead cycles plus the longest on-time (top plane, full brightness).
  function automatic int unsigned timer_width(int unsigned base_on, int unsigned bits,
                                              int unsigned blank);
    return $clog2(blank + (base_on << (bits - 1)) + 1);
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Panel OE timer: after a load, holds OE high for the dead cycles, then low for the on cycles.
module hub75_oe_timer #(
  parameter int unsigned TMR_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_dead,
  input  logic [TMR_W-1:0] i_on,
  output logic             o_oe,
  output logic             o_busy
);

  logic [TMR_W-1:0] r_cnt;
  logic [TMR_W-1:0] r_on;
  logic             r_oe;
  logic [TMR_W-1:0] w_cnt_dec;

  assign w_cnt_dec = r_cnt - 1'b1;

  // The count runs dead+on down to 0; the last `on` counts drive OE low.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_on  <= '0;
      r_oe  <= 1'b1;
    end else if (i_load) begin
      r_cnt <= i_dead + i_on;
      r_on  <= i_on;
      r_oe  <= !((i_dead == '0) && (i_on != '0));
    end else if (r_cnt != '0) begin
      r_cnt <= w_cnt_dec;
      r_oe  <= !((w_cnt_dec != '0) && (w_cnt_dec <= r_on));
    end else begin
      r_oe <= 1'b1;
    end
  end

  assign o_oe   = r_oe;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 scanner: shifts one bit plane per pass while the previous plane is displayed, then
// latches it with OE high and starts its plane-weighted, brightness-scaled on-time.
module hub75_bcm_driver
  import hub75_pkg::*;
#(
  parameter int unsigned COLS    = 128,
  parameter int unsigned ROWS    = 32,
  parameter int unsigned BITS    = 8,
  parameter int unsigned LANES   = 2,
  parameter int unsigned BASE_ON = 16,
  parameter int unsigned BLANK   = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [7:0]                 brightness,
  output logic                       rd_en,
  output logic [$clog2(ROWS)-1:0]    rd_row,
  output logic [$clog2(COLS)-1:0]    rd_col,
  input  logic [LANES*3*BITS-1:0]    rd_data,
  output logic                       clk_disp,
  output logic                       le,
  output logic                       oe,
  output logic [LANES*3-1:0]         sin,
  output logic [$clog2(ROWS)-1:0]    abcde,
  output logic                       frame_sync
);

  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned T_W     = $clog2(2 * COLS + 1);
  localparam int unsigned TMR_W   = timer_width(BASE_ON, BITS, BLANK);
  localparam int unsigned LANE_W  = 3 * BITS;

  localparam logic [T_W-1:0]     TLast     = T_W'(2 * COLS);
  localparam logic [COL_W-1:0]   ColLast   = COL_W'(COLS - 1);
  localparam logic [PLANE_W-1:0] PlaneLast = PLANE_W'(BITS - 1);
  localparam logic [ROW_W-1:0]   RowLast   = ROW_W'(ROWS - 1);

  shift_state_e        r_state;
  logic [T_W-1:0]      r_t;
  logic [PLANE_W-1:0]  r_plane;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    r_abcde;
  logic [COL_W-1:0]    r_rd_col;
  logic                r_rd_en;
  logic                r_clk_disp;
  logic                r_le;
  logic                r_frame_sync;
  logic [LANES*3-1:0]  r_sin;

  logic [COL_W-1:0]    w_col;
  logic [PLANE_W-1:0]  w_plane_next;
  logic [ROW_W-1:0]    w_row_next;
  logic [31:0]         w_bright_p1;
  logic [31:0]         w_on_full;
  logic [LANES*3-1:0]  w_sin;
  logic                w_load;
  logic                w_busy;
  logic                w_oe;

  assign w_col        = COL_W'(r_t >> 1);
  assign w_plane_next = (r_plane == PlaneLast) ? '0 : r_plane + 1'b1;
  assign w_row_next   = (r_plane != PlaneLast) ? r_row :
                        (r_row == RowLast)     ? '0    : r_row + 1'b1;

  assign w_bright_p1  = {24'd0, brightness} + 32'd1;
  assign w_on_full    = ((BASE_ON * w_bright_p1) >> 8) << r_plane;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LANE_W-1:0] w_lane_bits;
    assign w_lane_bits          = rd_data[l*LANE_W +: LANE_W] >> r_plane;
    assign w_sin[l*3 + ChR]     = w_lane_bits[ChR*BITS];
    assign w_sin[l*3 + ChG]     = w_lane_bits[ChG*BITS];
    assign w_sin[l*3 + ChB]     = w_lane_bits[ChB*BITS];
  end

  assign w_load = (r_state == StLatch);

  hub75_oe_timer #(
    .TMR_W (TMR_W)
  ) u_oe_timer (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_dead (TMR_W'(BLANK)),
    .i_on   (TMR_W'(w_on_full)),
    .o_oe   (w_oe),
    .o_busy (w_busy)
  );

  // Even t issues the next column read and drops clk_disp; odd t captures the column and raises it.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_t          <= '0;
      r_plane      <= '0;
      r_row        <= '0;
      r_abcde      <= '0;
      r_rd_col     <= '0;
      r_rd_en      <= 1'b0;
      r_clk_disp   <= 1'b0;
      r_le         <= 1'b0;
      r_frame_sync <= 1'b0;
      r_sin        <= '0;
    end else begin
      r_rd_en      <= 1'b0;
      r_le         <= 1'b0;
      r_frame_sync <= 1'b0;
      case (r_state)
        StIdle: begin
          if (en) begin
            r_state    <= StShift;
            r_t        <= '0;
            r_rd_en    <= 1'b1;
            r_rd_col   <= '0;
            r_clk_disp <= 1'b0;
          end
        end
        StShift: begin
          r_t <= r_t + 1'b1;
          if (r_t == TLast) begin
            r_state    <= StWait;
            r_clk_disp <= 1'b0;
          end else if (!r_t[0]) begin
            r_clk_disp <= 1'b0;
            if (w_col != ColLast) begin
              r_rd_en  <= 1'b1;
              r_rd_col <= w_col + 1'b1;
            end
          end else begin
            r_sin      <= w_sin;
            r_clk_disp <= 1'b1;
          end
        end
        StWait: begin
          // Latching only once OE is back high keeps row changes invisible.
          if (!w_busy) begin
            if (en) begin
              r_state <= StLatch;
              r_le    <= 1'b1;
              if (r_plane == '0) begin
                r_abcde      <= r_row;
                r_frame_sync <= (r_row == '0);
              end
            end else begin
              r_state <= StIdle;
              r_plane <= '0;
              r_row   <= '0;
            end
          end
        end
        StLatch: begin
          r_state    <= StShift;
          r_t        <= '0;
          r_rd_en    <= 1'b1;
          r_rd_col   <= '0;
          r_clk_disp <= 1'b0;
          r_plane    <= w_plane_next;
          r_row      <= w_row_next;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_row     = r_row;
  assign rd_col     = r_rd_col;
  assign clk_disp   = r_clk_disp;
  assign le         = r_le;
  assign oe         = w_oe;
  assign sin        = r_sin;
  assign abcde      = r_abcde;
  assign frame_sync = r_frame_sync;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver on a 4x2 panel, 3 bit planes, two lanes.
module tb_hub75_bcm_driver;

  localparam int COLS    = 4;
  localparam int ROWS    = 2;
  localparam int BITS    = 3;
  localparam int LANES   = 2;
  localparam int BASE_ON = 4;
  localparam int BLANK   = 2;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  brightness;
  logic        rd_en;
  logic [0:0]  rd_row;
  logic [1:0]  rd_col;
  logic [17:0] rd_data = '0;
  logic        clk_disp;
  logic        le;
  logic        oe;
  logic [5:0]  sin;
  logic [0:0]  abcde;
  logic        frame_sync;

  hub75_bcm_driver #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .BITS    (BITS),
    .LANES   (LANES),
    .BASE_ON (BASE_ON),
    .BLANK   (BLANK)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .brightness (brightness),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .clk_disp   (clk_disp),
    .le         (le),
    .oe         (oe),
    .sin        (sin),
    .abcde      (abcde),
    .frame_sync (frame_sync)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;
  int viol  = 0;
  int sh_row, sh_plane, rise_k;
  logic prev_clk;
  logic [0:0] prev_abcde = '0;

  typedef struct {
    logic [7:0] bright;
    int         on  [3];
    int         gap [3];
  } vec_t;
  vec_t tab [3];

  function automatic vec_t mk(logic [7:0] b, int o0, int o1, int o2, int g0, int g1, int g2);
    vec_t v;
    v.bright = b;
    v.on[0] = o0;  v.on[1] = o1;  v.on[2] = o2;
    v.gap[0] = g0; v.gap[1] = g1; v.gap[2] = g2;
    return v;
  endfunction

  function automatic logic [2:0] pix(int row, int col, int l, int c);
    return 3'((col * 3 + c * 5 + l * 2 + row * 7 + 1) % 8);
  endfunction

  function automatic logic [17:0] pack(int row, int col);
    logic [17:0] d = '0;
    for (int l = 0; l < LANES; l++)
      for (int c = 0; c < 3; c++)
        d[l*9 + c*3 +: 3] = pix(row, col, l, c);
    return d;
  endfunction

  function automatic logic [5:0] exp_sin(int row, int plane, int col);
    logic [5:0] s = '0;
    logic [2:0] v;
    for (int l = 0; l < LANES; l++)
      for (int c = 0; c < 3; c++) begin
        v = pix(row, col, l, c) >> plane;
        s[l*3 + c] = v[0];
      end
    return s;
  endfunction

  // Frame-buffer model: data for a read appears the cycle after rd_en and holds until the next.
  logic       rd_q = 1'b0;
  logic [0:0] row_q = '0;
  logic [1:0] col_q = '0;
  always @(negedge clk_in) begin
    if (rd_q) rd_data = pack(int'(row_q), int'(col_q));
    rd_q  = (rd_en === 1'b1);
    row_q = rd_row;
    col_q = rd_col;
  end

  always @(negedge clk_in) begin
    if (rst_n === 1'b1) begin
      if (abcde !== prev_abcde && oe !== 1'b1) viol++;
      if (le === 1'b1 && oe !== 1'b1) viol++;
    end
    prev_abcde = abcde;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_in);
    if (clk_disp === 1'b1 && prev_clk === 1'b0) begin
      chk("sin", 32'(sin), 32'(exp_sin(sh_row, sh_plane, rise_k)));
      rise_k++;
    end
    prev_clk = clk_disp;
  endtask

  task automatic on_le();
    if (sh_plane == 0) begin
      chk("abcde_at_le", 32'(abcde), sh_row);
      chk("frame_sync", 32'(frame_sync), 32'(sh_row == 0));
    end else begin
      chk("frame_sync", 32'(frame_sync), 0);
    end
    chk("clk_rises", rise_k, COLS);
    rise_k = 0;
    if (sh_plane == BITS - 1) begin
      sh_plane = 0;
      sh_row   = (sh_row + 1) % ROWS;
    end else begin
      sh_plane++;
    end
  endtask

  // From an le cycle to the next: leading OE-high cycles, OE-low cycles, and the le spacing.
  task automatic measure(output int gap, output int dead, output int low);
    logic [7:0] saved = brightness;
    bit seen_low = 0;
    gap = 0; dead = 0; low = 0;
    do begin
      cyc();
      gap++;
      if (gap == 3) brightness = ~saved;
      if (oe === 1'b0) begin
        low++;
        seen_low = 1;
      end else if (!seen_low) begin
        dead++;
      end
    end while (le !== 1'b1 && gap < 100);
    brightness = saved;
  endtask

  task automatic check_plane(input vec_t v, input int p);
    int gap, dead, low;
    measure(gap, dead, low);
    chk("le_gap", gap, v.gap[p]);
    if (v.on[p] > 0) begin
      chk("dead_cycles", dead, BLANK);
      chk("oe_low_cycles", low, v.on[p]);
    end else begin
      chk("oe_low_cycles", low, 0);
    end
    on_le();
  endtask

  task automatic first_le(input string name);
    int t;
    for (t = 0; t < 40; t++) begin
      cyc();
      if (le === 1'b1) break;
    end
    chk(name, t, 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t, nrd, nle;
    int cols [4];
    tab[0] = mk(8'd255, 4, 8, 16, 11, 12, 20);
    tab[1] = mk(8'd127, 2, 4, 8, 11, 11, 12);
    tab[2] = mk(8'd0,   0, 0, 0, 11, 11, 11);
    sh_row = 0; sh_plane = 0; rise_k = 0; prev_clk = 1'bx;

    // Reset held with en high.
    rst_n = 1'b0; en = 1'b1; brightness = 8'd255;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_outputs", 32'({oe, le, clk_disp, sin, abcde, rd_en, frame_sync}),
          32'(12'b1_0_0_000000_0_0_0));
    end
    rst_n = 1'b1;

    // First pass: column reads, shifted bits, latch timing.
    nrd = 0;
    for (t = 0; t < 40; t++) begin
      cyc();
      if (rd_en === 1'b1) begin
        if (nrd < 4) cols[nrd] = int'(rd_col);
        nrd++;
      end
      if (le === 1'b1) break;
    end
    chk("first_le_time", t, 10);
    chk("read_count", nrd, COLS);
    for (int i = 0; i < 4; i++) chk("rd_col_seq", cols[i], i);
    on_le();

    // Brightness table across rows 0, 1, 0 including the row wrap.
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < BITS; p++) begin
        if (p == 0) brightness = tab[i].bright;
        check_plane(tab[i], p);
      end
    end

    // Drop en during a shift: pass completes, no latch, FSM returns to idle.
    for (int i = 0; i < 3; i++) cyc();
    en = 1'b0;
    nle = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (le === 1'b1) nle++;
    end
    chk("le_after_en_low", nle, 0);
    chk("rises_after_en_low", rise_k, COLS);
    chk("rd_row_idle", 32'(rd_row), 0);
    chk("rd_en_idle", 32'(rd_en), 0);
    chk("abcde_held", 32'(abcde), 1);
    chk("oe_idle", 32'(oe), 1);

    // Restart from row 0 plane 0.
    brightness = 8'd255;
    sh_row = 0; sh_plane = 0; rise_k = 0;
    en = 1'b1;
    cyc();
    chk("restart_rd_en", 32'(rd_en), 1);
    chk("restart_rd_row", 32'(rd_row), 0);
    chk("restart_rd_col", 32'(rd_col), 0);
    for (t = 1; t < 40; t++) begin
      cyc();
      if (le === 1'b1) break;
    end
    chk("restart_le_time", t, 10);
    on_le();
    check_plane(tab[0], 0);
    check_plane(tab[0], 1);

    // Reset while plane 2 is on.
    t = 0;
    do begin
      cyc();
      t++;
    end while (oe !== 1'b0 && t < 10);
    chk("plane2_oe_low", 32'(oe), 0);
    for (int i = 0; i < 3; i++) cyc();
    rst_n = 1'b0;
    cyc();
    chk("reset_mid_display", 32'({oe, le, clk_disp, rd_en}), 32'(4'b1000));
    cyc();
    rst_n = 1'b1;
    sh_row = 0; sh_plane = 0; rise_k = 0;
    first_le("post_reset_le_time");
    on_le();

    chk("blank_violations", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
